// File: rtl/lenet5_loader_if.sv
// Word stream carrying weights, biases and pixels into the loader.
// Valid/ready handshake: a word moves when valid && ready on a rising clock edge.
interface lenet5_loader_if #(
    parameter int DATA_BW = 32
);
    logic [DATA_BW-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lenet5_loader.sv
// Routes the word stream to the LeNet-5 weight/bias/fmap ports, runs inference, latches the class.
// Strobes and data lag acceptance by 1 cycle; ready depends on state only, 1 word/cycle across phases.
module lenet5_loader #(
    parameter int DATA_BW  = 32,
    parameter int W_BW     = 8,
    parameter int B_BW     = 16,
    parameter int I_BW     = 8,
    parameter int N_WEIGHT = 3220,
    parameter int N_BIAS   = 10,
    parameter int N_PIXEL  = 784,
    parameter int TIMEOUT  = 200000
) (
    input  logic              clk,
    input  logic              user_reset,
    input  logic              i_start,
    input  logic              i_reload,
    lenet5_loader_if.slave    s_in,
    output logic              o_ce,
    output logic [W_BW-1:0]   o_weight,
    output logic              o_weight_we,
    output logic [B_BW-1:0]   o_bias,
    output logic              o_bias_we,
    output logic [I_BW-1:0]   o_fmap,
    output logic              o_fmap_we,
    input  logic [3:0]        i_class_result,
    input  logic              i_class_en,
    input  logic              i_class_end,
    output logic [3:0]        o_result,
    output logic              o_done,
    output logic              o_error,
    output logic              o_busy,
    output logic              o_params_loaded
);
    localparam int N_MAX = (N_WEIGHT > N_BIAS) ? ((N_WEIGHT > N_PIXEL) ? N_WEIGHT : N_PIXEL)
                                               : ((N_BIAS > N_PIXEL) ? N_BIAS : N_PIXEL);
    localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int RUN_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD_W, ST_LOAD_B, ST_LOAD_F, ST_RUN, ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic               params_q, params_d;
    logic               error_q, error_d;
    logic [3:0]         r_result_q, r_result_d;
    logic [3:0]         result_q, result_d;

    logic [W_BW-1:0]    weight_q;
    logic [B_BW-1:0]    bias_q;
    logic [I_BW-1:0]    fmap_q;
    logic               weight_we_q, bias_we_q, fmap_we_q;
    logic               accept;

    logic [DATA_BW-1:0] unused_data;
    assign unused_data = s_in.data;

    assign accept = s_in.valid && s_in.ready;

    always_ff @(posedge clk) begin
        if (user_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            run_cnt_q  <= '0;
            params_q   <= 1'b0;
            error_q    <= 1'b0;
            r_result_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_cnt_q  <= run_cnt_d;
            params_q   <= params_d;
            error_q    <= error_d;
            r_result_q <= r_result_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_cnt_d  = run_cnt_q;
        params_d   = params_q;
        error_d    = error_q;
        r_result_d = r_result_q;
        result_d   = result_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    error_d = 1'b0;
                    cnt_d   = '0;
                    // Biases/weights stay resident unless a reload is asked for or a load was cut short
                    if (i_reload || !params_q) begin
                        state_d  = ST_LOAD_W;
                        params_d = 1'b0;
                    end else begin
                        state_d = ST_LOAD_F;
                    end
                end
            end
            ST_LOAD_W: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(N_WEIGHT - 1)) begin
                        state_d = ST_LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(N_BIAS - 1)) begin
                        state_d  = ST_LOAD_F;
                        cnt_d    = '0;
                        params_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD_F: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(N_PIXEL - 1)) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        run_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (i_class_en) begin
                    r_result_d = i_class_result;
                end
                // End wins over a coincident timeout; a result arriving with end is taken first
                if (i_class_end) begin
                    state_d  = ST_DONE;
                    result_d = i_class_en ? i_class_result : r_result_q;
                end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_in.ready = 1'b0;
        o_ce       = 1'b0;
        o_busy     = (state_q != ST_IDLE);
        o_done     = (state_q == ST_DONE);
        case (state_q)
            ST_LOAD_W, ST_LOAD_B, ST_LOAD_F: begin
                s_in.ready = 1'b1;
                o_ce       = 1'b1;
            end
            ST_RUN:  o_ce = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (user_reset) begin
            weight_q    <= '0;
            bias_q      <= '0;
            fmap_q      <= '0;
            weight_we_q <= 1'b0;
            bias_we_q   <= 1'b0;
            fmap_we_q   <= 1'b0;
        end else begin
            weight_we_q <= accept && (state_q == ST_LOAD_W);
            bias_we_q   <= accept && (state_q == ST_LOAD_B);
            fmap_we_q   <= accept && (state_q == ST_LOAD_F);
            if (accept && (state_q == ST_LOAD_W)) weight_q <= s_in.data[W_BW-1:0];
            if (accept && (state_q == ST_LOAD_B)) bias_q   <= s_in.data[B_BW-1:0];
            if (accept && (state_q == ST_LOAD_F)) fmap_q   <= s_in.data[I_BW-1:0];
        end
    end

    assign o_weight        = weight_q;
    assign o_weight_we     = weight_we_q;
    assign o_bias          = bias_q;
    assign o_bias_we       = bias_we_q;
    assign o_fmap          = fmap_q;
    assign o_fmap_we       = fmap_we_q;
    assign o_result        = result_q;
    assign o_error         = error_q;
    assign o_params_loaded = params_q;
endmodule

// File: tb/tb_lenet5_loader.sv
// Bench for lenet5_loader: model predicts the routed word stream, strobe timing and inference outcome.
module tb_lenet5_loader;
    localparam int NW = 4;
    localparam int NB = 2;
    localparam int NP = 3;
    localparam int TO = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        user_reset, i_start, i_reload;
    logic        o_ce, o_weight_we, o_bias_we, o_fmap_we, o_done, o_error, o_busy, o_params_loaded;
    logic [7:0]  o_weight, o_fmap;
    logic [15:0] o_bias;
    logic [3:0]  i_class_result, o_result;
    logic        i_class_en, i_class_end;

    lenet5_loader_if #(.DATA_BW(32)) s_if ();

    lenet5_loader #(
        .DATA_BW(32), .W_BW(8), .B_BW(16), .I_BW(8),
        .N_WEIGHT(NW), .N_BIAS(NB), .N_PIXEL(NP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .user_reset(user_reset), .i_start(i_start), .i_reload(i_reload),
        .s_in(s_if),
        .o_ce(o_ce), .o_weight(o_weight), .o_weight_we(o_weight_we),
        .o_bias(o_bias), .o_bias_we(o_bias_we), .o_fmap(o_fmap), .o_fmap_we(o_fmap_we),
        .i_class_result(i_class_result), .i_class_en(i_class_en), .i_class_end(i_class_end),
        .o_result(o_result), .o_done(o_done), .o_error(o_error), .o_busy(o_busy),
        .o_params_loaded(o_params_loaded)
    );

    typedef struct { int cyc; int kind; int val; } ev_t;  // kind: 0 weight, 1 bias, 2 fmap

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   pl_rise = -1;
    int   exp_pl_rise = -1;
    logic prev_pl = 1'b0;
    ev_t  obs[$];
    ev_t  exp_q[$];
    int   seq[$];        // remaining word kinds the loader should still accept
    bit   m_params = 1'b0;
    int   m_result = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_weight_we) obs.push_back('{cyc, 0, int'(o_weight)});
        if (o_bias_we)   obs.push_back('{cyc, 1, int'(o_bias)});
        if (o_fmap_we)   obs.push_back('{cyc, 2, int'(o_fmap)});
        if (o_done) done_cnt++;
        if (o_params_loaded && !prev_pl) pl_rise = cyc;
        prev_pl = o_params_loaded;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic do_start(input bit reload);
        bit full;
        full = reload || !m_params;
        i_start = 1'b1; i_reload = reload;
        @(negedge clk);
        i_start = 1'b0; i_reload = 1'b0;
        if (full) begin
            m_params = 1'b0;
            for (int i = 0; i < NW; i++) seq.push_back(0);
            for (int i = 0; i < NB; i++) seq.push_back(1);
        end
        for (int i = 0; i < NP; i++) seq.push_back(2);
        checks++;
        if (s_if.ready !== 1'b1 || o_busy !== 1'b1 || o_ce !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: ready=%b busy=%b ce=%b, required 1 1 1", s_if.ready, o_busy, o_ce);
        end
        checks++;
        if (o_error !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_error: o_error=%b, required 0", o_error);
        end
        checks++;
        if (o_params_loaded !== m_params) begin
            errors++;
            $display("FAIL start_params: o_params_loaded=%b, required %b", o_params_loaded, m_params);
        end
    endtask

    // Offers words until n are accepted; pat gives valid for the first 8 offers, rnd randomises it
    task automatic stream(input int n, input logic [7:0] pat, input bit rnd, input bit fixed, input int base);
        int acc, guard, k;
        logic [31:0] w;
        bit v;
        acc = 0; guard = 0;
        while (acc < n && guard < 500) begin
            v = (guard < 8) ? pat[guard] : 1'b1;
            if (rnd) v = ($urandom_range(3) != 0);
            w = fixed ? 32'(base + acc) : $urandom;
            s_if.valid = v; s_if.data = w;
            #1;
            checks++;
            if (s_if.ready !== (seq.size() != 0)) begin
                errors++;
                $display("FAIL ready_in_load: o_ready=%b, required %b", s_if.ready, seq.size() != 0);
            end
            if (v && s_if.ready && seq.size() != 0) begin
                k = seq.pop_front();
                exp_q.push_back('{cyc + 1, k, (k == 1) ? int'(w[15:0]) : int'(w[7:0])});
                if (k == 1 && (seq.size() == 0 || seq[0] != 1)) begin
                    m_params = 1'b1;
                    exp_pl_rise = cyc + 1;
                end
                acc++;
            end
            @(negedge clk);
            guard++;
        end
        s_if.valid = 1'b0;
        checks++;
        if (acc < n) begin
            errors++;
            $display("FAIL stream_accept: accepted=%0d, required %0d", acc, n);
        end
    endtask

    task automatic drain_compare(input string name);
        @(negedge clk);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d, required %0d", name, obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < obs.size(); i++) begin
                checks++;
                if (obs[i].cyc != exp_q[i].cyc || obs[i].kind != exp_q[i].kind || obs[i].val != exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s strobe[%0d]: cyc=%0d kind=%0d val=%0h, required cyc=%0d kind=%0d val=%0h",
                             name, i, obs[i].cyc, obs[i].kind, obs[i].val,
                             exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
                end
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic run_infer(input int n_en, input bit fixed, input bit conc);
        int last;
        last = 0;
        for (int i = 0; i < n_en; i++) begin
            i_class_en = 1'b1;
            i_class_result = fixed ? ((i == 0) ? 4'd3 : 4'd7) : 4'($urandom_range(9));
            last = int'(i_class_result);
            @(negedge clk);
            i_class_en = 1'b0;
            if (!fixed && $urandom_range(1) == 1) @(negedge clk);
        end
        i_class_end = 1'b1;
        if (conc) begin
            i_class_en = 1'b1;
            i_class_result = 4'($urandom_range(9));
            last = int'(i_class_result);
        end
        @(negedge clk);
        i_class_end = 1'b0; i_class_en = 1'b0;
        m_result = last;
        checks++;
        if (o_done !== 1'b1 || o_result !== 4'(m_result) || o_ce !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: done=%b result=%0d ce=%b, required 1 %0d 0", o_done, o_result, o_ce, m_result);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_result !== 4'(m_result)) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b result=%0d, required 0 0 %0d", o_done, o_busy, o_result, m_result);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (o_ce !== 1'b0 || s_if.ready !== 1'b0 || o_weight_we !== 1'b0 || o_bias_we !== 1'b0 ||
            o_fmap_we !== 1'b0 || o_weight !== 8'd0 || o_bias !== 16'd0 || o_fmap !== 8'd0 ||
            o_result !== 4'd0 || o_done !== 1'b0 || o_error !== 1'b0 || o_busy !== 1'b0 ||
            o_params_loaded !== 1'b0) begin
            errors++;
            $display("FAIL %s: ce=%b rdy=%b we=%b%b%b w=%0h b=%0h f=%0h res=%0d done=%b err=%b busy=%b pl=%b, required all 0",
                     name, o_ce, s_if.ready, o_weight_we, o_bias_we, o_fmap_we, o_weight, o_bias, o_fmap,
                     o_result, o_done, o_error, o_busy, o_params_loaded);
        end
    endtask

    task automatic test_reset();
        check_reset_values("reset_state");
    endtask

    task automatic test_full_load();
        pl_rise = -1;
        do_start(1'b1);
        stream(NW + NB + NP, 8'hFF, 1'b0, 1'b1, 1);
        checks++;
        if (s_if.ready !== 1'b0 || o_ce !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL run_entry: ready=%b ce=%b busy=%b, required 0 1 1", s_if.ready, o_ce, o_busy);
        end
        drain_compare("full_load");
        checks++;
        if (pl_rise != exp_pl_rise || o_params_loaded !== 1'b1) begin
            errors++;
            $display("FAIL params_rise: cycle=%0d level=%b, required cycle=%0d level 1", pl_rise, o_params_loaded, exp_pl_rise);
        end
    endtask

    task automatic test_inference();
        run_infer(2, 1'b1, 1'b0);
    endtask

    task automatic test_fmap_only();
        do_start(1'b0);
        stream(NP, 8'hFF, 1'b0, 1'b0, 0);
        drain_compare("fmap_only");
        run_infer(1, 1'b0, 1'b1);
    endtask

    task automatic test_stalls();
        do_start(1'b1);
        stream(NW + NB + NP, 8'hF9, 1'b0, 1'b0, 0);
        drain_compare("stalls");
        run_infer(3, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int run_cycles, d0, guard;
        do_start(1'b0);
        stream(NP, 8'hFF, 1'b0, 1'b0, 0);
        drain_compare("timeout_load");
        // One RUN cycle has already elapsed during the drain
        run_cycles = 1; d0 = done_cnt; guard = 0;
        i_class_en = 1'b1; i_class_result = 4'((m_result + 1) % 10);
        i_start = 1'b1;
        while (o_ce && guard < 100) begin
            run_cycles++;
            @(negedge clk);
            i_class_en = 1'b0; i_start = 1'b0;
            guard++;
        end
        checks++;
        if (run_cycles != TO) begin
            errors++;
            $display("FAIL timeout_length: run cycles=%0d, required %0d", run_cycles, TO);
        end
        checks++;
        if (o_error !== 1'b1 || o_busy !== 1'b0 || done_cnt != d0 || o_result !== 4'(m_result)) begin
            errors++;
            $display("FAIL timeout_state: err=%b busy=%b done_pulses=%0d result=%0d, required 1 0 0 %0d",
                     o_error, o_busy, done_cnt - d0, o_result, m_result);
        end
        do_start(1'b0);
        stream(NP, 8'hFF, 1'b1, 1'b0, 0);
        drain_compare("after_timeout");
        run_infer(1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        do_start(1'b1);
        stream(NW + 1, 8'hFF, 1'b0, 1'b0, 0);
        user_reset = 1'b1;
        @(negedge clk);
        user_reset = 1'b0;
        check_reset_values("reset_mid_load");
        obs.delete(); exp_q.delete(); seq.delete();
        m_params = 1'b0; m_result = 0;
        do_start(1'b0);
        stream(NW + NB + NP, 8'hFF, 1'b1, 1'b0, 0);
        drain_compare("reload_after_reset");
        run_infer(2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 4; it++) begin
            do_start(1'($urandom_range(1)));
            stream(seq.size(), 8'hFF, 1'($urandom_range(1)), 1'b0, 0);
            drain_compare("random_session");
            run_infer(1 + $urandom_range(2), 1'b0, 1'($urandom_range(1)));
        end
    endtask

    initial begin
        user_reset = 1'b1; i_start = 1'b0; i_reload = 1'b0;
        s_if.valid = 1'b0; s_if.data = '0;
        i_class_en = 1'b0; i_class_end = 1'b0; i_class_result = '0;
        repeat (3) @(negedge clk);
        test_reset();
        user_reset = 1'b0;
        @(negedge clk);
        test_full_load();
        test_inference();
        test_fmap_only();
        test_stalls();
        test_timeout();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lenet5_loader.md
# lenet5_loader

Front-end sequencer that sits directly upstream of the LeNet-5 core and drives its weight, bias and feature-map load ports. It accepts a valid/ready word stream from the AXI4-lite register slave and routes each word to the correct core input according to a load-phase state machine. It then holds the core enable while inference runs and captures the classification result. Weights and biases stay resident across images, so later images reload only the feature map.

## Interface
- DATA_BW, 32, width of incoming word stream
- W_BW, 8, weight width (word bits [W_BW-1:0])
- B_BW, 16, FC bias width (word bits [B_BW-1:0])
- I_BW, 8, pixel width (word bits [I_BW-1:0])
- N_WEIGHT, 3220, weights per full load
- N_BIAS, 10, FC biases per full load
- N_PIXEL, 784, pixels per image (28x28)
- TIMEOUT, 200000, max RUN cycles before error
- clk  in  1  single clock, all logic on rising edge
- user_reset  in  1  synchronous, active-high reset
- i_start  in  1  start pulse, sampled in IDLE only
- i_reload  in  1  sampled with i_start; 1 forces weight+bias reload
- i_data  in  DATA_BW  stream word
- i_valid  in  1  word valid
- o_ready  out  1  word accepted when i_valid && o_ready
- o_ce  out  1  core enable
- o_weight  out  W_BW  to core weight input
- o_weight_we  out  1  weight write strobe
- o_bias  out  B_BW  to core bias input
- o_bias_we  out  1  bias write strobe
- o_fmap  out  I_BW  to core fmap input
- o_fmap_we  out  1  fmap write strobe
- i_class_result  in  4  core classification result
- i_class_en  in  1  core result valid
- i_class_end  in  1  core end-of-inference pulse
- o_result  out  4  latched class (0-9)
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  sticky timeout flag, cleared by i_start
- o_busy  out  1  high in any state except IDLE
- o_params_loaded  out  1  weights and biases resident

## Operation
- States: IDLE, LOAD_W, LOAD_B, LOAD_F, RUN, DONE.
- IDLE: on i_start, clear o_error. If i_reload or !o_params_loaded, go to LOAD_W and clear o_params_loaded. Otherwise go to LOAD_F.
- LOAD_W: o_ready=1. Each accepted word drives o_weight=i_data[W_BW-1:0] with o_weight_we=1. On word N_WEIGHT-1, go to LOAD_B.
- LOAD_B: same handling for bias, signed slice [B_BW-1:0]. On word N_BIAS-1, set o_params_loaded and go to LOAD_F.
- LOAD_F: same handling for pixels. On word N_PIXEL-1, go to RUN.
- One shared element counter, cleared on every phase transition. Width is clog2 of the largest N.
- o_ce: high in LOAD_W, LOAD_B, LOAD_F and RUN; low in IDLE and DONE.
- RUN: o_ready=0.
  - Each i_class_en latches i_class_result into r_result; the last one before end wins.
  - On i_class_end, go to DONE. If i_class_en is also high that cycle, latch that result first.
  - Cycle counter cleared on RUN entry. If it reaches TIMEOUT, set o_error and go to IDLE; o_result keeps its previous value.
- DONE: o_result=r_result and o_done=1 for exactly one cycle, then IDLE.
- Stalls: i_valid low inside a load phase just pauses. Counter and state hold, and all strobes are 0.
- i_start outside IDLE is ignored. i_valid in IDLE, RUN or DONE is not accepted (o_ready=0).

## Timing
- o_ready is combinational from state only, never from i_valid.
- Data outputs and strobes are registered: a word accepted in cycle t appears at the core in t+1. Strobes are high for exactly one cycle per accepted word.
- Phase boundary: the last word of a phase is accepted with the state still in that phase. The next phase accepts from t+1, giving back-to-back throughput of 1 word/cycle across phases.
- Data outputs hold their last value when the strobe is low.
- Reset values: state=IDLE, all strobes 0, o_ce=0, o_ready=0, o_weight/o_bias/o_fmap=0, o_result=0, o_done=0, o_error=0, o_busy=0, o_params_loaded=0.
- Reset mid-phase (user_reset at any cycle): all of the above apply on the next edge. A partial load leaves o_params_loaded=0, so the next i_start performs a full reload.
- i_start to first o_ready: 1 cycle. i_class_end to o_done: 1 cycle.

## Test plan
Bench runs with N_WEIGHT=4, N_BIAS=2, N_PIXEL=3, TIMEOUT=20.
- Full load: i_start, i_reload=1, 9 back-to-back words 0x01..0x09.
  - o_weight_we pulses carry 1..4, o_bias_we pulses carry 5..6, o_fmap_we pulses carry 7..9, each 1 cycle after acceptance.
  - o_params_loaded rises after word 6. State is RUN after word 9.
- Inference: in RUN, pulse i_class_en with result 3 and then 7, then i_class_end.
  - Next cycle: o_done=1, o_result=7, o_ce=0. Then IDLE.
- Fmap-only reload: second i_start with i_reload=0 enters LOAD_F directly. 3 words produce only o_fmap_we pulses; no weight or bias strobes.
- Stalls: i_valid toggled 1,0,0,1 during LOAD_W.
  - Counter advances only on accepted words; strobes are 0 during gaps.
  - The phase ends after exactly 4 accepted words.
- Timeout: no i_class_end for 20 RUN cycles.
  - o_error=1, state IDLE, o_done never pulses, o_result unchanged.
  - The next i_start clears o_error.
- Reset mid-LOAD_B after 1 bias word: all outputs return to reset values. The next i_start with i_reload=0 still enters LOAD_W.
